// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory access, byte-lane shift and load extension.
// Optional misaligned-access fault when LSU_MISALIGN_CHECK_EN is defined.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wmask,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_wmask;
    logic [2:0]  r_funct3;
    logic        r_wen;
    logic        r_fault;
    logic        w_accept;
    logic        w_misalign;
    logic [31:0] w_x;
    logic [31:0] w_ext;

    assign w_accept = (r_state == IDLE) && req_valid;

`ifdef LSU_MISALIGN_CHECK_EN
    // funct3[1:0]: 00 byte, 01 half, anything else is treated as a word
    always_comb begin
        w_misalign = 1'b0;
        unique case (1'b1)
            (req_funct3[1:0] == 2'b00): w_misalign = 1'b0;
            (req_funct3[1:0] == 2'b01): w_misalign = req_addr[0];
            default:                    w_misalign = |req_addr[1:0];
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = w_misalign ? RESP : REQ;
            REQ:     if (dmem_gnt) w_next = WAIT;
            WAIT:    if (dmem_rvalid) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_x = dmem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ext = w_x;
        unique case (1'b1)
            (r_funct3 == 3'b000): w_ext = {{24{w_x[7]}}, w_x[7:0]};
            (r_funct3 == 3'b100): w_ext = {24'd0, w_x[7:0]};
            (r_funct3 == 3'b001): w_ext = {{16{w_x[15]}}, w_x[15:0]};
            (r_funct3 == 3'b101): w_ext = {16'd0, w_x[15:0]};
            default:              w_ext = w_x;
        endcase
    end

    // r_rdata/r_fault are only non-zero while in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wmask  <= '0;
            r_funct3 <= '0;
            r_wen    <= 1'b0;
            r_rdata  <= '0;
            r_fault  <= 1'b0;
        end else if (w_accept) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_wmask  <= req_wmask;
            r_funct3 <= req_funct3;
            r_wen    <= req_wen;
            r_rdata  <= '0;
            r_fault  <= w_misalign;
        end else if (r_state == WAIT && dmem_rvalid) begin
            r_rdata  <= r_wen ? 32'd0 : w_ext;
        end else if (r_state == RESP) begin
            r_rdata  <= '0;
            r_fault  <= 1'b0;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign dmem_req   = (r_state == REQ);
    assign resp_valid = (r_state == RESP);
    assign resp_fault = r_fault;
    assign resp_rdata = r_rdata;
    assign dmem_we    = r_wen;
    assign dmem_addr  = {r_addr[31:2], 2'b00};
    assign dmem_wmask = r_wen ? r_wmask : 4'b0000;
    assign dmem_wdata = r_wdata << {r_addr[1:0], 3'b000};

endmodule
